operand_buffer_loader: RTL and testbench
========================================

Name: operand_buffer_loader

Overview:
- Responder side of the accelerator's buffer handshake. The control FSM supplies a base address and a load request; this block fetches consecutive words from on-chip memory and writes them into a local operand buffer.
- Asserts buf_full once all words have landed, so the FSM can advance to compute.
- Holds the data until the consumer releases the buffer.
- Instantiated twice: once as the weight buffer (drives WB_full), once as the input buffer (drives InB_full).

Parameters:
- ADDR_W, 16, memory word-address width.
- DATA_W, 16, data word width.
- DEPTH, 256, buffer entries; must be a power of 2.
- MAX_OUT, 4, maximum outstanding memory reads; must be at least the memory read latency.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- load_req  in  1  single-cycle request to start a fill.
- base_addr  in  ADDR_W  first memory address; sampled when load_req is accepted.
- load_len  in  $clog2(DEPTH)+1  number of words, 1..DEPTH; sampled when load_req is accepted.
- busy  out  1  high in ISSUE or WAIT.
- buf_full  out  1  buffer holds a complete fill.
- buf_release  in  1  consumer done with the data; clears buf_full.
- mem_rd_en  out  1  memory read request.
- mem_addr  out  ADDR_W  memory read address.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rd_valid  in  1  read data valid; responses return in order.
- mem_rd_data  in  DATA_W  read data.
- buf_rd_addr  in  $clog2(DEPTH)  consumer read index.
- buf_rd_data  out  DATA_W  buffer word; registered, 1-cycle latency.
- fill_count  out  $clog2(DEPTH)+1  number of words written in the current fill.

Behaviour:
- Reset values: busy=0, buf_full=0, mem_rd_en=0, mem_addr=0, fill_count=0, buf_rd_data=0. State goes to IDLE. Issue, write and outstanding counters clear to 0.
- Reset during a fill aborts it. Responses arriving after reset are dropped, because outstanding=0. Buffer contents are not cleared.
- States:
  - IDLE: on load_req with load_len≠0, latch base_addr and len=min(load_len, DEPTH), clear counters, go to ISSUE. load_req with load_len=0 is ignored and the state stays IDLE.
  - ISSUE:
    - mem_rd_en=1 and mem_addr=base+issued when issued<len and outstanding<MAX_OUT.
    - A request counts as issued only when mem_rd_en & mem_gnt. Then issued and outstanding increment.
    - When issued==len, go to WAIT.
  - WAIT: mem_rd_en=0. Go to FULL on the cycle the final response is written (written==len).
  - FULL:
    - buf_full=1. On buf_release, go to IDLE; buf_full deasserts the next cycle.
    - If buf_release and load_req arrive in the same cycle with load_len≠0, latch the new request and go directly to ISSUE (back-to-back fills). buf_full drops the same way.
- Response handling in ISSUE and WAIT:
  - When mem_rd_valid and outstanding>0, write mem_rd_data to buffer[written], then increment written and fill_count.
  - outstanding decrements on each response.
  - A grant and a response in the same cycle leave outstanding unchanged.
- Responses are ignored in IDLE, in FULL, and whenever outstanding==0.
- Address arithmetic is modulo 2^ADDR_W; base+issued wraps silently.
- load_req is ignored in ISSUE and WAIT; busy tells the requester why.
- Latency with mem_gnt held at 1 and memory latency L: first mem_rd_en appears 1 cycle after load_req. buf_full asserts at load_req + 1 + len + L cycles, give or take 1 depending on the write register.
- Buffer read port:
  - buf_rd_data = buffer[buf_rd_addr], registered.
  - Valid at any time; only meaningful while buf_full=1.
  - A read of the entry being written returns the old data (read-first).

Decomposition:
- Package accel_pkg holds:
  - loader state enum (IDLE, ISSUE, WAIT, FULL);
  - constants ACC_ADDR_W=16, ACC_DATA_W=16, ACC_BUF_DEPTH=256;
  - layer MAC counts shared with the control FSM.
- Sub-module: operand_buffer_ram. Simple dual-port, one write port and one registered read port, read-first, DEPTH×DATA_W.
- The FSM, counters and outstanding tracking live in the top module.

Test Plan:
1. Basic fill: base_addr=0x0100, load_len=256, mem_gnt=1, memory latency 2 → addresses 0x0100..0x01FF issued once each in order; buf_full rises at cycle 259±1; buffer[i]=mem[0x0100+i].
2. Backpressure: mem_gnt toggles 1,0,1,0 with latency 3 and MAX_OUT=4 → no address is skipped or duplicated; outstanding never exceeds 4; fill_count=load_len at buf_full.
3. Wrap and clamp: base_addr=0xFFF0, load_len=300 → len clamped to 256; addresses run 0xFFF0..0xFFFF then 0x0000..0x00EF.
4. Back-to-back: while FULL, assert buf_release and load_req (base 0x0200, len=10) in the same cycle → buf_full=0 the next cycle, ISSUE entered directly, buf_full again after 10 words.
5. Ignored requests: load_req while busy, load_len=0 in IDLE, and a stray mem_rd_valid in IDLE → no state change and no buffer write.
6. Reset mid-fill: rst after 5 of 20 grants, then 2 late mem_rd_valid pulses → all outputs at reset values; late data not written; fill_count=0.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: buffer geometry, loader states
// and per-layer MAC counts used by the control FSM.
package accel_pkg;

    localparam int ACC_ADDR_W    = 16;
    localparam int ACC_DATA_W    = 16;
    localparam int ACC_BUF_DEPTH = 256;

    localparam int unsigned L0_MACS = 32'd200704;
    localparam int unsigned L1_MACS = 32'd524288;
    localparam int unsigned L2_MACS = 32'd65536;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FULL
    } loader_state_e;

    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned depth
    );
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/operand_buffer_ram.sv
// Simple dual-port operand storage: one write port and a
// registered, read-first read port.
module operand_buffer_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle read of the entry being written sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/operand_buffer_loader.sv
// Fills the local operand buffer from on-chip memory with up to
// MAX_OUT reads in flight, then holds it until the consumer releases it.
module operand_buffer_loader
    import accel_pkg::*;
#(
    parameter int ADDR_W  = ACC_ADDR_W,
    parameter int DATA_W  = ACC_DATA_W,
    parameter int DEPTH   = ACC_BUF_DEPTH,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_req,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [$clog2(DEPTH):0]   load_len,
    output logic                     busy,
    output logic                     buf_full,
    input  logic                     buf_release,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rd_valid,
    input  logic [DATA_W-1:0]        mem_rd_data,
    input  logic [$clog2(DEPTH)-1:0] buf_rd_addr,
    output logic [DATA_W-1:0]        buf_rd_data,
    output logic [$clog2(DEPTH):0]   fill_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    loader_state_e     state;
    logic [ADDR_W-1:0] base_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     issued;
    logic [LW-1:0]     written;
    logic [OW-1:0]     outstanding;

    logic          active;
    logic          fire;
    logic          resp_ok;
    logic          start;
    logic [LW-1:0] req_len;
    logic [LW-1:0] issued_nx;
    logic [LW-1:0] written_nx;

    assign active = (state == ST_ISSUE) || (state == ST_WAIT);
    assign busy = active;
    assign buf_full = (state == ST_FULL);
    assign fill_count = written;

    assign mem_rd_en = (state == ST_ISSUE)
                    && (issued < len_q)
                    && (outstanding < OW'(MAX_OUT));
    assign mem_addr = base_q + ADDR_W'(issued);

    assign fire = mem_rd_en & mem_gnt;
    // Stray or post-abort responses are dropped when nothing is in flight.
    assign resp_ok = active && mem_rd_valid && (outstanding != '0);

    assign issued_nx = issued + LW'(fire);
    assign written_nx = written + LW'(resp_ok);

    assign req_len = LW'(clamp_len(32'(load_len), DEPTH));
    assign start = load_req && (load_len != '0)
                && ((state == ST_IDLE)
                 || ((state == ST_FULL) && buf_release));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued      <= '0;
            written     <= '0;
            outstanding <= '0;
        end else begin
            if (active) begin
                issued      <= issued_nx;
                written     <= written_nx;
                outstanding <= outstanding + OW'(fire) - OW'(resp_ok);
            end

            unique case (state)
                ST_IDLE: begin
                    if (start) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (written_nx == len_q) state <= ST_FULL;
                    else if (issued_nx == len_q) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (written_nx == len_q) state <= ST_FULL;
                end
                ST_FULL: begin
                    if (start) state <= ST_ISSUE;
                    else if (buf_release) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (start) begin
                base_q      <= base_addr;
                len_q       <= req_len;
                issued      <= '0;
                written     <= '0;
                outstanding <= '0;
            end
        end
    end

    operand_buffer_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (resp_ok),
        .waddr (written[AW-1:0]),
        .wdata (mem_rd_data),
        .raddr (buf_rd_addr),
        .rdata (buf_rd_data)
    );

endmodule

// File: tb/tb_operand_buffer_loader.sv
// Directed and randomized fills of operand_buffer_loader against an
// in-order memory responder and an address/contents reference model.
module tb_operand_buffer_loader;

    localparam int DEPTH   = 256;
    localparam int LW      = 9;
    localparam int MAX_OUT = 4;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic [15:0] base_addr;
    logic [8:0]  load_len;
    logic        busy;
    logic        buf_full;
    logic        buf_release;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_data;
    logic [7:0]  buf_rd_addr;
    logic [15:0] buf_rd_data;
    logic [8:0]  fill_count;

    operand_buffer_loader #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req     (load_req),
        .base_addr    (base_addr),
        .load_len     (load_len),
        .busy         (busy),
        .buf_full     (buf_full),
        .buf_release  (buf_release),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .buf_rd_addr  (buf_rd_addr),
        .buf_rd_data  (buf_rd_data),
        .fill_count   (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    req_t        pq[$];
    logic [15:0] glog[$];
    logic [15:0] bufm [DEPTH];
    int cyc, lat, gmode, stray, delivered, maxq;
    int checks, errors;

    function automatic logic [15:0] memword(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: fixed latency, in-order, grant pattern per gmode.
    task automatic mem_step();
        req_t r;
        cyc++;
        if (pq.size() > maxq) maxq = pq.size();
        mem_rd_valid = 1'b0;
        mem_rd_data = 16'h0;
        if (rst) begin
            pq.delete();
            mem_gnt = 1'b0;
            return;
        end
        case (gmode)
            0: mem_gnt = 1'b1;
            1: mem_gnt = (cyc % 2) == 0;
            default: mem_gnt = ($urandom_range(0, 3) != 0);
        endcase
        if (stray > 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data = 16'hDEAD;
            stray--;
        end else if (pq.size() > 0 && pq[0].due <= cyc) begin
            r = pq.pop_front();
            mem_rd_valid = 1'b1;
            mem_rd_data = memword(r.addr);
            delivered++;
        end
        if (mem_rd_en && mem_gnt) begin
            pq.push_back('{mem_addr, cyc + lat});
            glog.push_back(mem_addr);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_buffer(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            buf_rd_addr = 8'(i);
            tick();
            if (buf_rd_data !== bufm[i]) bad++;
        end
        chk({tag, " buffer_bad_entries"}, bad, 0);
    endtask

    task automatic release_buf(input string tag);
        buf_release = 1'b1;
        tick();
        buf_release = 1'b0;
        chk({tag, " release_full"}, buf_full, 0);
        chk({tag, " release_busy"}, busy, 0);
    endtask

    task automatic run_fill(input logic [15:0] base, input int len,
                            input int l, input int gm, input bit b2b,
                            input bit poke, input string tag,
                            output int ncyc);
        int n, exp_n, bad;
        logic [15:0] ea;
        lat = l;
        gmode = gm;
        glog.delete();
        maxq = 0;
        base_addr = base;
        load_len = LW'(len);
        load_req = 1'b1;
        buf_release = b2b;
        tick();
        load_req = 1'b0;
        buf_release = 1'b0;
        if (b2b) begin
            chk({tag, " b2b_full_drop"}, buf_full, 0);
            chk({tag, " b2b_busy"}, busy, 1);
        end
        n = 1;
        while (!buf_full && n < 3000) begin
            if (poke && n == 3) begin
                load_req = 1'b1;
                base_addr = 16'h7777;
                load_len = 9'd5;
            end else begin
                load_req = 1'b0;
            end
            tick();
            n++;
        end
        load_req = 1'b0;
        ncyc = n;
        chk({tag, " reached_full"}, buf_full, 1);
        exp_n = (len > DEPTH) ? DEPTH : len;
        chk({tag, " fill_count"}, fill_count, exp_n);
        chk({tag, " grant_count"}, glog.size(), exp_n);
        bad = 0;
        for (int i = 0; i < glog.size() && i < exp_n; i++) begin
            ea = base + 16'(i);
            if (glog[i] !== ea) bad++;
        end
        chk({tag, " addr_seq_bad"}, bad, 0);
        chk({tag, " max_outstanding_ok"}, maxq <= MAX_OUT, 1);
        for (int i = 0; i < exp_n; i++) bufm[i] = memword(base + 16'(i));
        check_buffer(tag);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " buf_full"}, buf_full, 0);
        chk({tag, " mem_rd_en"}, mem_rd_en, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " fill_count"}, fill_count, 0);
        chk({tag, " buf_rd_data"}, buf_rd_data, 0);
    endtask

    initial begin
        int n;
        logic [15:0] rb;
        int rl, rlat;
        checks = 0;
        errors = 0;
        cyc = 0;
        lat = 2;
        gmode = 0;
        stray = 0;
        delivered = 0;
        maxq = 0;
        rst = 1'b1;
        load_req = 1'b0;
        base_addr = 16'h0;
        load_len = 9'd0;
        buf_release = 1'b0;
        mem_gnt = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data = 16'h0;
        buf_rd_addr = 8'd0;

        tick();
        tick();
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();

        run_fill(16'h0100, 256, 2, 0, 1'b0, 1'b0, "t1_basic", n);
        chk("t1_basic full_latency_in_window", (n >= 258 && n <= 260), 1);
        release_buf("t1");

        run_fill(16'h0300, 40, 3, 1, 1'b0, 1'b0, "t2_backpressure", n);
        release_buf("t2");

        run_fill(16'hFFF0, 300, 2, 0, 1'b0, 1'b0, "t3_wrap_clamp", n);

        run_fill(16'h0200, 10, 2, 0, 1'b1, 1'b1, "t4_b2b", n);
        release_buf("t4");

        glog.delete();
        base_addr = 16'h4444;
        load_len = 9'd0;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
        chk("t5 zero_len_busy", busy, 0);
        chk("t5 zero_len_rd_en", mem_rd_en, 0);
        stray = 1;
        tick();
        tick();
        tick();
        chk("t5 stray_fill_count", fill_count, 10);
        chk("t5 no_grants", glog.size(), 0);
        check_buffer("t5");

        for (int k = 0; k < 3; k++) begin
            rb = 16'($urandom);
            rl = $urandom_range(1, 300);
            rlat = $urandom_range(1, 4);
            run_fill(rb, rl, rlat, 2, 1'b0, 1'b0, "rand", n);
            release_buf("rand");
        end

        lat = 2;
        gmode = 0;
        glog.delete();
        delivered = 0;
        base_addr = 16'h0800;
        load_len = 9'd20;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        n = 0;
        while (glog.size() < 5 && n < 100) begin
            tick();
            n++;
        end
        chk("t6 five_grants", glog.size(), 5);
        rst = 1'b1;
        tick();
        chk_reset_outs("t6_in_reset");
        rst = 1'b0;
        stray = 2;
        tick();
        tick();
        tick();
        tick();
        chk("t6 fill_count", fill_count, 0);
        chk("t6 busy", busy, 0);
        chk("t6 buf_full", buf_full, 0);
        for (int i = 0; i < delivered; i++) bufm[i] = memword(16'h0800 + 16'(i));
        check_buffer("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
